// File: rtl/arb_request_queue.sv
// arb_request_queue: per-lane pending-request counters feeding a round-robin arbiter.
// Each lane counts posted events and retires one per granted cycle. It reports
// fill level, full and sticky overflow per lane.
// Optional macro ARB_REQQ_STARVE_EN adds per-lane age counters and sticky
// starvation flags. When the macro is undefined, starve is tied to 0.
module arb_request_queue #(
  parameter int N            = 3,
  parameter int DEPTH_W      = 3,
  parameter int AGE_W        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         evt,
  input  logic [N-1:0]         gnt,
  input  logic                 flag_clr,
  output logic [N-1:0]         req,
  output logic [N*DEPTH_W-1:0] pend_cnt,
  output logic [N-1:0]         full,
  output logic [N-1:0]         ovf,
  output logic [N-1:0]         starve
);

  localparam logic [DEPTH_W-1:0] CNT_MAX = '1;

  logic [N-1:0][DEPTH_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]              ovf_q, ovf_d;

  // Per-lane count update. A simultaneous event and grant cancel out, even on a
  // full lane (no overflow) or an empty one (the grant consumes the event).
  always_comb begin
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = cnt_q[i];
      ovf_d[i] = ovf_q[i] & ~flag_clr;
      unique case ({evt[i], gnt[i]})
        2'b10: begin
          if (cnt_q[i] == CNT_MAX) ovf_d[i] = 1'b1;
          else                     cnt_d[i] = cnt_q[i] + 1'b1;
        end
        2'b01: begin
          if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Count and overflow registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      ovf_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  // The request and full outputs are decoded from the registered count only.
  // This keeps the arbiter's input free of any path from evt or gnt.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      req[i]  = (cnt_q[i] != '0);
      full[i] = (cnt_q[i] == CNT_MAX);
    end
  end

  assign pend_cnt = cnt_q;
  assign ovf      = ovf_q;

`ifdef ARB_REQQ_STARVE_EN
  localparam logic [AGE_W-1:0] AGE_LIM = AGE_W'(STARVE_LIMIT);

  logic [N-1:0][AGE_W-1:0] age_q, age_d;
  logic [N-1:0]            starve_q, starve_d;

  // The age counter runs while the lane waits ungranted and saturates at the
  // limit. The starve flag sets only on the edge where the age first reaches
  // the limit.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      age_d[i]    = '0;
      starve_d[i] = starve_q[i] & ~flag_clr;
      if (req[i] && !gnt[i]) begin
        if (age_q[i] != AGE_LIM) age_d[i] = age_q[i] + 1'b1;
        else                     age_d[i] = age_q[i];
      end
      if ((age_q[i] != AGE_LIM) && (age_d[i] == AGE_LIM)) starve_d[i] = 1'b1;
    end
  end

  // Age and starvation registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      age_q    <= '0;
      starve_q <= '0;
    end else begin
      age_q    <= age_d;
      starve_q <= starve_d;
    end
  end

  assign starve = starve_q;
`else
  logic unused_starve_cfg;
  assign unused_starve_cfg = ^{AGE_W, STARVE_LIMIT};
  assign starve            = '0;
`endif

endmodule

// File: doc/arb_request_queue.md
# arb_request_queue

Per-requester pending-request queue that sits directly upstream of the round-robin arbiter. Each requester posts single-cycle request events; the block counts outstanding events per lane, drives the arbiter's `req` vector while any are pending, and retires one event per lane each cycle that lane's `gnt` bit is high. It also reports fill level, full, overflow and, optionally, starvation status per lane.

## Interface
- `N`, 3: number of requester lanes. Matches the arbiter width.
- `DEPTH_W`, 3: pending-counter width. Maximum pending count is 2^DEPTH_W-1 (7 at default).
- `AGE_W`, 4: starvation age counter width.
- `STARVE_LIMIT`, 8: age value at which `starve[i]` sets. Must be ≤ 2^AGE_W-1.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `evt` in N: per-lane request event, one event per high cycle.
- `gnt` in N: grant vector from the arbiter, sampled at the rising edge.
- `flag_clr` in 1: clears the sticky `ovf` and `starve` flags.
- `req` out N: `req[i] = (cnt[i] != 0)`. Combinational from the registered count; feeds the arbiter.
- `pend_cnt` out N*DEPTH_W: lane i count is on bits `[i*DEPTH_W +: DEPTH_W]`.
- `full` out N: `full[i] = (cnt[i] == 2^DEPTH_W-1)`.
- `ovf` out N: sticky. Set when an event is dropped.
- `starve` out N: sticky starvation flag. Held at 0 when the feature is compiled out.

## Operation
- All N lanes are independent. `gnt` is not checked for one-hot; each lane acts only on its own bit.
- Per-lane count update at each edge, with `max` = 2^DEPTH_W-1:
  - `evt=1, gnt=0, cnt<max`: cnt+1.
  - `evt=1, gnt=0, cnt==max`: cnt unchanged; `ovf[i]` sets.
  - `evt=0, gnt=1, cnt>0`: cnt-1.
  - `evt=0, gnt=1, cnt==0`: ignored; no underflow, no flag.
  - `evt=1, gnt=1`: net zero, cnt unchanged. This applies even when full (no overflow) and when empty; when empty, the event is consumed by the grant.
  - `evt=0, gnt=0`: hold.
- `flag_clr` clears all `ovf` and `starve` bits at the edge. A set condition in the same cycle wins: the flag remains 1.
- `flag_clr` does not affect counts.
- Reset mid-operation: all counts, flags and age counters go to 0 at the edge, and pending events are discarded.
  - `evt` in the reset cycle is dropped.
  - `req` is 0 in the cycle after reset.

## Timing
- Reset values: `req`=0, `pend_cnt`=0, `full`=0, `ovf`=0, `starve`=0.
- Event latency: `evt[i]` high in cycle t with empty lane gives `req[i]` high from cycle t+1.
- Grant retire: `gnt[i]` high in cycle t with cnt=1 gives `req[i]` low from cycle t+1.
  - The arbiter therefore sees deasserted `req` one cycle after the last grant. There is no extra grant.
- Throughput: one event posted and one retired per lane per cycle. Sustained `evt`=`gnt`=1 holds the count constant.
- `full` and `ovf` update on the same edge as the count. `ovf` is visible the cycle after the dropped event.

## Configuration
- `ARB_REQQ_STARVE_EN` defined: per-lane `age` counter (AGE_W bits) is compiled in.
  - Increments each cycle with `req[i]=1` and `gnt[i]=0`.
  - Clears to 0 on `gnt[i]=1` or `req[i]=0`.
  - Saturates at STARVE_LIMIT.
  - On the edge where `age` reaches STARVE_LIMIT, `starve[i]` sets and stays set until `flag_clr` or reset.
- `ARB_REQQ_STARVE_EN` not defined: no age logic and `starve` tied to 0. All other behaviour is identical.

## Test plan
- **Reset:** assert `rst` 2 cycles with `evt`=3'b111 → all outputs 0; `req`=0 the cycle after release.
- **Fill and overflow:** 9 cycles `evt`=3'b001, `gnt`=0 → `pend_cnt` lane0 reaches 7 after 7 edges and `full[0]`=1; `ovf[0]`=1 after the 8th edge; count stays 7. Then `flag_clr` pulse → `ovf`=0, count still 7.
- **Drain:** lane1 cnt=2, `gnt`=3'b010 for 3 cycles → cnt 1, 0, 0; `req[1]` low after the 2nd edge; no underflow, `ovf`=0.
- **Simultaneous events:**
  - Lane2 full (7) with `evt[2]`=`gnt[2]`=1 for 4 cycles → count stays 7, `ovf[2]`=0.
  - Empty lane with both high → count stays 0, `req` stays 0.
- **Arbiter loop:** `evt`=3'b111 for 2 cycles into a round-robin arbiter → 6 grants rotating 0→1→2→0→1→2, then `req`=0 and all counts 0.
- **Starvation (`ARB_REQQ_STARVE_EN`):** lane0 cnt=1, `gnt`=0 for 8 cycles → `starve[0]`=1 after the 8th edge. A `gnt[0]` pulse then leaves `starve[0]`=1 until `flag_clr`. With the macro undefined, `starve` stays 0 throughout.
